// File: rtl/vend_pkg.sv
// Shared types, state encodings and the product price table for the vending controller.
package vend_pkg;

  localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
  localparam logic [2:0] ST_SELECT_ENC   = 3'd1;
  localparam logic [2:0] ST_PAY_ENC      = 3'd2;
  localparam logic [2:0] ST_DISPENSE_ENC = 3'd3;
  localparam logic [2:0] ST_RETURN_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_SELECT   = ST_SELECT_ENC,
    ST_PAY      = ST_PAY_ENC,
    ST_DISPENSE = ST_DISPENSE_ENC,
    ST_RETURN   = ST_RETURN_ENC
  } state_e;

  // Fixed price list; slots beyond the table are free (price 0).
  function automatic logic [7:0] price_of(input logic [31:0] code);
    case (code)
      32'd0:   price_of = 8'd10;
      32'd1:   price_of = 8'd50;
      32'd2:   price_of = 8'd30;
      32'd3:   price_of = 8'd20;
      32'd4:   price_of = 8'd15;
      32'd5:   price_of = 8'd25;
      32'd6:   price_of = 8'd40;
      32'd7:   price_of = 8'd5;
      default: price_of = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_inventory.sv
// Per-slot stock counters with a read port, a dispense decrement and a restock add.
module vend_inventory #(
  parameter int NUM_PRODUCTS = 8,
  parameter int CODE_W       = 3,
  parameter int STOCK_W      = 4,
  parameter int INIT_STOCK   = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [CODE_W-1:0]  i_rd_code,
  output logic [STOCK_W-1:0] o_rd_stock,
  input  logic               i_dec_valid,
  input  logic [CODE_W-1:0]  i_dec_code,
  input  logic               i_rs_valid,
  input  logic [CODE_W-1:0]  i_rs_code,
  input  logic [STOCK_W-1:0] i_rs_qty
);

  localparam logic [STOCK_W:0] MAX_STOCK = {1'b0, {STOCK_W{1'b1}}};

  logic [STOCK_W-1:0] r_stock [NUM_PRODUCTS];
  logic [STOCK_W:0]   w_sum   [NUM_PRODUCTS];
  logic [STOCK_W-1:0] w_next  [NUM_PRODUCTS];

  // Read mux; codes outside the slot range read as empty.
  always_comb begin
    o_rd_stock = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++)
      if (i_rd_code == CODE_W'(i)) o_rd_stock = r_stock[i];
  end

  // Net update: add restock, remove the dispensed unit, then saturate once.
  always_comb begin
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      w_sum[i] = {1'b0, r_stock[i]};
      if (i_rs_valid && i_rs_code == CODE_W'(i))
        w_sum[i] = w_sum[i] + {1'b0, i_rs_qty};
      if (i_dec_valid && i_dec_code == CODE_W'(i) && w_sum[i] != '0)
        w_sum[i] = w_sum[i] - (STOCK_W+1)'(1);
      w_next[i] = (w_sum[i] > MAX_STOCK) ? MAX_STOCK[STOCK_W-1:0] : w_sum[i][STOCK_W-1:0];
    end
  end

  // Stock registers, reloaded to the initial fill on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      for (int i = 0; i < NUM_PRODUCTS; i++) r_stock[i] <= w_next[i];
    end
  end

endmodule

// File: rtl/vend_ctrl_param.sv
// Multi-product vending controller: selection, incremental coin payment, timeout refund, dispense.
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS   = 8,
  parameter int CODE_W         = $clog2(NUM_PRODUCTS),
  parameter int VALUE_W        = 8,
  parameter int STOCK_W        = 4,
  parameter int INIT_STOCK     = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_cancel,
  input  logic [CODE_W-1:0]  i_product_code,
  input  logic               i_online_payment,
  input  logic               i_coin_valid,
  input  logic [VALUE_W-1:0] i_coin_value,
  input  logic               i_restock_valid,
  input  logic [CODE_W-1:0]  i_restock_code,
  input  logic [STOCK_W-1:0] i_restock_qty,
  output logic [2:0]         o_state,
  output logic [VALUE_W-1:0] o_product_price,
  output logic [VALUE_W-1:0] o_balance,
  output logic               o_dispense_product,
  output logic [CODE_W-1:0]  o_dispensed_code,
  output logic               o_change_valid,
  output logic [VALUE_W-1:0] o_return_change,
  output logic               o_sold_out,
  output logic               o_coin_reject
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

  state_e             r_state;
  logic [CODE_W-1:0]  r_code;
  logic [VALUE_W-1:0] r_price;
  logic [VALUE_W-1:0] r_balance;
  logic [VALUE_W-1:0] r_change;
  logic               r_online;
  logic [TMR_W-1:0]   r_timer;
  logic               r_dispense;
  logic [CODE_W-1:0]  r_disp_code;
  logic               r_change_valid;
  logic               r_sold_out;
  logic               r_coin_reject;

  logic [STOCK_W-1:0] w_sel_stock;
  logic               w_code_ok;
  logic [VALUE_W:0]   w_sum;
  logic               w_coin_ovf;
  logic               w_coin_acc;
  logic [VALUE_W-1:0] w_bal_next;
  logic [VALUE_W-1:0] w_eff_price;
  logic [VALUE_W-1:0] w_disp_change;

  vend_inventory #(
    .NUM_PRODUCTS(NUM_PRODUCTS), .CODE_W(CODE_W),
    .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)
  ) u_inv (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rd_code(i_product_code), .o_rd_stock(w_sel_stock),
    .i_dec_valid(r_state == ST_DISPENSE), .i_dec_code(r_code),
    .i_rs_valid(i_restock_valid), .i_rs_code(i_restock_code), .i_rs_qty(i_restock_qty)
  );

  // Coin arithmetic one bit wide so an overflowing coin can be rejected instead of wrapping.
  assign w_code_ok     = 32'(i_product_code) < 32'(NUM_PRODUCTS);
  assign w_sum         = {1'b0, r_balance} + {1'b0, i_coin_value};
  assign w_coin_ovf    = i_coin_valid && w_sum[VALUE_W];
  assign w_coin_acc    = i_coin_valid && !w_sum[VALUE_W];
  assign w_bal_next    = w_coin_acc ? w_sum[VALUE_W-1:0] : r_balance;
  assign w_eff_price   = r_online ? '0 : r_price;
  assign w_disp_change = (r_balance >= w_eff_price) ? (r_balance - w_eff_price) : '0;

  // Transaction FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_code         <= '0;
      r_price        <= '0;
      r_balance      <= '0;
      r_change       <= '0;
      r_online       <= 1'b0;
      r_timer        <= '0;
      r_dispense     <= 1'b0;
      r_disp_code    <= '0;
      r_change_valid <= 1'b0;
      r_sold_out     <= 1'b0;
      r_coin_reject  <= 1'b0;
    end else begin
      r_dispense     <= 1'b0;
      r_disp_code    <= '0;
      r_change_valid <= 1'b0;
      r_sold_out     <= 1'b0;
      r_coin_reject  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) r_state <= ST_SELECT;
        end
        ST_SELECT: begin
          if (i_cancel) begin
            r_change       <= '0;
            r_change_valid <= 1'b1;
            r_state        <= ST_RETURN;
          end else if (i_start) begin
            if (!w_code_ok || w_sel_stock == '0) begin
              r_sold_out <= 1'b1;
            end else begin
              r_code  <= i_product_code;
              r_price <= VALUE_W'(price_of(32'(i_product_code)));
              r_timer <= TMR_LOAD;
              r_state <= ST_PAY;
            end
          end
        end
        ST_PAY: begin
          // A coin is banked even on cancel/timeout so it is part of the refund.
          r_coin_reject <= w_coin_ovf;
          r_balance     <= w_bal_next;
          if (i_coin_valid)         r_timer <= TMR_LOAD;
          else if (r_timer != '0)   r_timer <= r_timer - TMR_W'(1);
          if (i_cancel || r_timer == '0) begin
            r_change       <= w_bal_next;
            r_change_valid <= 1'b1;
            r_state        <= ST_RETURN;
          end else if (i_online_payment) begin
            r_online    <= 1'b1;
            r_dispense  <= 1'b1;
            r_disp_code <= r_code;
            r_state     <= ST_DISPENSE;
          end else if (w_coin_acc && w_bal_next >= r_price) begin
            r_dispense  <= 1'b1;
            r_disp_code <= r_code;
            r_state     <= ST_DISPENSE;
          end
        end
        ST_DISPENSE: begin
          r_change       <= w_disp_change;
          r_change_valid <= 1'b1;
          r_state        <= ST_RETURN;
        end
        ST_RETURN: begin
          r_balance <= '0;
          r_price   <= '0;
          r_code    <= '0;
          r_online  <= 1'b0;
          r_change  <= '0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_state            = r_state;
  assign o_product_price    = r_price;
  assign o_balance          = r_balance;
  assign o_dispense_product = r_dispense;
  assign o_dispensed_code   = r_disp_code;
  assign o_change_valid     = r_change_valid;
  assign o_return_change    = r_change;
  assign o_sold_out         = r_sold_out;
  assign o_coin_reject      = r_coin_reject;

endmodule
